// File: rtl/rd_ddr3_pkg.sv
// rd_ddr3_pkg
// Shared constants and types for the PL DDR3 read-path stages.
//   DDR_DATA_W          : width of one DataMover read word
//   DEFAULT_FRAME_WORDS : words per output frame (one 320-byte read)
//   frame_cnt_t         : 16-bit word/frame counter type
package rd_ddr3_pkg;
  localparam int DDR_DATA_W          = 32;
  localparam int DEFAULT_FRAME_WORDS = 80;
  localparam int FRAME_CNT_W         = 16;

  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
endpackage

// File: rtl/rd_ddr3_sync_fifo.sv
// rd_ddr3_sync_fifo
// Synchronous FIFO with fall-through read data (rd_data always shows the
// word at the read pointer), used as the storage behind the AXIS output
// register of rd_ddr3_frame_buf.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous flush (pointers and level to 0), beats wr/rd
//   wr_en     : write request; ignored while full (caller flags overflow)
//   wr_data   : write word
//   rd_en     : pop request; ignored while empty
//   rd_data   : word at the read pointer
//   level     : occupancy in words, 0 .. 2^ADDR_W
//   full      : level == 2^ADDR_W
//   empty     : level == 0
module rd_ddr3_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;
  assign rd_data = mem[rptr];

  // Storage is not reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/rd_ddr3_frame_buf.sv
// rd_ddr3_frame_buf
// Buffers the un-throttled DataMover MM2S word stream in a FIFO and re-emits
// it as an AXI4-Stream master, with tlast every FRAME_WORDS words. The
// upstream cannot be stalled, so words arriving while full are dropped and
// reported through the sticky ovf flag.
// Optional build macro: RD_DDR3_FRAME_BUF_CNT_EN adds frame_cnt[15:0], a
// wrapping count of completed frames (cleared by rst and soft_clr).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   soft_clr       : synchronous flush of FIFO, output register and framing
//                    counter (ovf is kept); a coincident in_en word is lost
//   in_en, in_data : input word stream, no backpressure
//   m_axis_*       : AXI4-Stream master (tvalid, tready, tdata, tlast)
//   frame_done     : one-cycle pulse after the tlast word is accepted
//   level          : FIFO occupancy, excluding the output register
//   ovf, clr_ovf   : sticky overflow flag and its clear (set wins)
//   frame_cnt      : completed-frame count (only with the macro defined)
//
// Handshake: a word transfers on a rising edge where tvalid && tready. Once
// tvalid is raised, tdata/tlast stay unchanged and tvalid stays high until
// that transfer happens; tvalid never depends on tready.
module rd_ddr3_frame_buf
  import rd_ddr3_pkg::*;
#(
  parameter int DATA_W      = DDR_DATA_W,
  parameter int ADDR_W      = 9,
  parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_clr,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  input  logic              clr_ovf
`ifdef RD_DDR3_FRAME_BUF_CNT_EN
  ,
  output frame_cnt_t        frame_cnt
`endif
);
  localparam frame_cnt_t LAST_IDX = frame_cnt_t'(FRAME_WORDS - 1);
  localparam frame_cnt_t CNT_ONE  = frame_cnt_t'(1);

  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_data;
  logic              accept;
  logic              load;
  logic              overflow;
  frame_cnt_t        word_cnt;
  frame_cnt_t        next_idx;

  rd_ddr3_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (soft_clr),
    .wr_en   (in_en),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (fifo_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign accept   = m_axis_tvalid && m_axis_tready;
  assign load     = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
  assign overflow = in_en && fifo_full && !soft_clr;

  // word_cnt is the frame index of the word currently in the output register
  // (or of the next word if the register is empty). If that word is being
  // accepted this cycle, the word loading behind it takes the following index.
  always_comb begin
    next_idx = word_cnt;
    if (accept) next_idx = m_axis_tlast ? '0 : word_cnt + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      word_cnt      <= '0;
    end else if (soft_clr) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      word_cnt      <= '0;
    end else begin
      frame_done <= accept && m_axis_tlast;
      if (accept) word_cnt <= next_idx;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= fifo_data;
        m_axis_tlast  <= (next_idx == LAST_IDX);
      end else if (accept) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

  // Set has priority over clear so an overflow is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (clr_ovf)  ovf <= 1'b0;
  end

`ifdef RD_DDR3_FRAME_BUF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (soft_clr)   frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + CNT_ONE;
  end
`endif
endmodule
